seq_det_param: RTL



---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_hist.sv | 41 ++++
 rtl/seq_det_param.sv | 66 ++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial sequence detector.
// Holds the default pattern geometry and a helper sizing the history fill counter.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic [3:0] PAT_DEF = 4'b1001;

  // fill counts 0..PAT_W-1, so clog2(PAT_W) bits suffice; keep at least one bit
  function automatic int fill_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

  localparam int FILL_W = fill_width(PAT_W_DEF);

endpackage

// File: rtl/seq_det_hist.sv
// Shift window of the last PAT_W-1 accepted bits plus a saturating fill counter.
// full marks that every history bit came from the current stream (no stale bits).
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  input  logic             restart,
  input  logic             xin,
  output logic [PAT_W-1:0] w,
  output logic             full
);

  localparam int FW = fill_width(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;

  assign w    = {hist, xin};
  assign full = (fill == FILL_MAX);

  // restart empties fill but still shifts, so a non-overlapping hit needs PAT_W fresh bits
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= w[PAT_W-2:0];
      if (restart)
        fill <= '0;
      else if (!full)
        fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector: reloadable pattern, overlap select, sample enable.
// Define SEQ_DET_CNT_EN to add the saturating match_cnt output.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEF)
`ifdef SEQ_DET_CNT_EN
  , parameter int             CNT_W   = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             xin,
  input  logic             en,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             y
`ifdef SEQ_DET_CNT_EN
  , output logic [CNT_W-1:0] match_cnt
`endif
);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] w;
  logic             full;
  logic             accept;
  logic             hit;

  // a load on the same edge as a sample wins and the sample is dropped
  assign accept = en && !pat_load;
  assign hit    = accept && full && (w == pat);

  seq_det_hist #(.PAT_W(PAT_W)) u_hist (
    .clk     (clk),
    .reset   (reset),
    .shift   (accept),
    .clear   (pat_load),
    .restart (hit && !overlap),
    .xin     (xin),
    .w       (w),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pat <= PAT_RST;
      y   <= 1'b0;
    end else begin
      if (pat_load)
        pat <= pat_in;
      y <= hit;
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || pat_load)
      match_cnt <= '0;
    else if (hit && (match_cnt != {CNT_W{1'b1}}))
      match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule
